// File: rtl/rics_multicycle_ctrl.sv
// Multi-cycle control sequencer (IF/ID/EX/MEM/WB) decoding op/funct into datapath strobes.
// Optional RICS_ILLEGAL_TRAP_EN: unknown encodings trap to HALT and raise `illegal`.
module rics_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             pc_we,
    output logic             pc_br,
    output logic             ir_we,
    output logic             rf_we,
    output logic             reg_dst_rt,
    output logic             alu_src_imm,
    output logic [2:0]       alu_op,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
`ifdef RICS_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_ALUI, K_LW, K_SW, K_BEQ, K_BAD
    } kind_t;

    state_t     cur_st, nxt_st;
    kind_t      kind;
    logic [2:0] dec_alu;
    logic       retire;

    always_comb begin
        kind    = K_BAD;
        dec_alu = 3'b000;
        case (op)
            6'b000000: begin
                kind = K_R;
                case (funct)
                    6'b100000: dec_alu = 3'b010;
                    6'b100010: dec_alu = 3'b110;
                    6'b100100: dec_alu = 3'b000;
                    6'b100101: dec_alu = 3'b001;
                    6'b100110: dec_alu = 3'b011;
                    6'b100111: dec_alu = 3'b100;
                    6'b101010: dec_alu = 3'b111;
                    default:   kind    = K_BAD;
                endcase
            end
            6'b001000: begin kind = K_ALUI; dec_alu = 3'b010; end
            6'b001100: begin kind = K_ALUI; dec_alu = 3'b000; end
            6'b001101: begin kind = K_ALUI; dec_alu = 3'b001; end
            6'b001110: begin kind = K_ALUI; dec_alu = 3'b011; end
            6'b100011: begin kind = K_LW;   dec_alu = 3'b010; end
            6'b101011: begin kind = K_SW;   dec_alu = 3'b010; end
            6'b000100: begin kind = K_BEQ;  dec_alu = 3'b110; end
            default:   kind = K_BAD;
        endcase
    end

    always_comb begin
        nxt_st      = cur_st;
        pc_we       = 1'b0;
        pc_br       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        reg_dst_rt  = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 3'b000;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;

        // ALU controls and write-port select stay stable from EX through WB
        if ((cur_st == S_EX || cur_st == S_MEM || cur_st == S_WB) && kind != K_BAD) begin
            alu_op      = dec_alu;
            alu_src_imm = (kind == K_ALUI) || (kind == K_LW) || (kind == K_SW);
            reg_dst_rt  = (kind == K_ALUI) || (kind == K_LW);
        end

        case (cur_st)
            S_IF: begin
                // rst gate keeps the fetch strobes quiet while reset is held
                if (run && mem_rdy && !rst) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    nxt_st = S_ID;
                end
            end
            S_ID: nxt_st = S_EX;
            S_EX: begin
                case (kind)
                    K_R, K_ALUI: nxt_st = S_WB;
                    K_LW, K_SW:  nxt_st = S_MEM;
                    K_BEQ: begin
                        pc_we  = zero;
                        pc_br  = zero;
                        retire = 1'b1;
                        nxt_st = S_IF;
                    end
                    default: begin
`ifdef RICS_ILLEGAL_TRAP_EN
                        nxt_st = S_HALT;
`else
                        retire = 1'b1;
                        nxt_st = S_IF;
`endif
                    end
                endcase
            end
            S_MEM: begin
                mem_re = (kind == K_LW);
                mem_we = (kind == K_SW);
                if (mem_rdy) begin
                    if (kind == K_LW) begin
                        nxt_st = S_WB;
                    end else begin
                        retire = 1'b1;
                        nxt_st = S_IF;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                mem_to_reg = (kind == K_LW);
                retire     = 1'b1;
                nxt_st     = S_IF;
            end
            S_HALT:  nxt_st = S_HALT;
            default: nxt_st = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st  <= S_IF;
            retired <= '0;
        end else begin
            cur_st <= nxt_st;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign state = cur_st;

`ifdef RICS_ILLEGAL_TRAP_EN
    assign illegal = (cur_st == S_HALT);
`endif

endmodule

// File: tb/tb_rics_multicycle_ctrl.sv
// Bench for rics_multicycle_ctrl: vector table, corner sequences, randomized trace vs. reference model.
module tb_rics_multicycle_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, run, zero, mem_rdy;
    logic [5:0]    op, funct;
    logic          pc_we, pc_br, ir_we, rf_we, reg_dst_rt, alu_src_imm;
    logic          mem_re, mem_we, mem_to_reg;
    logic [2:0]    alu_op, state;
    logic [CW-1:0] retired;
`ifdef RICS_ILLEGAL_TRAP_EN
    logic          illegal;
`endif

    int tests   = 0;
    int fails   = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    rics_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .funct(funct), .zero(zero),
        .mem_rdy(mem_rdy), .pc_we(pc_we), .pc_br(pc_br), .ir_we(ir_we), .rf_we(rf_we),
        .reg_dst_rt(reg_dst_rt), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .mem_re(mem_re), .mem_we(mem_we), .mem_to_reg(mem_to_reg), .state(state),
        .retired(retired)
`ifdef RICS_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_e;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        logic [2:0] alu;
        logic       imm;
        logic       rdst;
        int         cyc;
        int         rfw;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f,
                                       output logic [2:0] a);
        a = 3'd0;
        if (o == 6'b000000) begin
            case (f)
                6'b100000: a = 3'd2;
                6'b100010: a = 3'd6;
                6'b100100: a = 3'd0;
                6'b100101: a = 3'd1;
                6'b100110: a = 3'd3;
                6'b100111: a = 3'd4;
                6'b101010: a = 3'd7;
                default:   return K_BAD;
            endcase
            return K_R;
        end
        case (o)
            6'b001000: begin a = 3'd2; return K_I;   end
            6'b001100: begin a = 3'd0; return K_I;   end
            6'b001101: begin a = 3'd1; return K_I;   end
            6'b001110: begin a = 3'd3; return K_I;   end
            6'b100011: begin a = 3'd2; return K_LW;  end
            6'b101011: begin a = 3'd2; return K_SW;  end
            6'b000100: begin a = 3'd6; return K_BEQ; end
            default:   return K_BAD;
        endcase
    endfunction

    function automatic logic [14:0] obs();
        return {state, pc_we, pc_br, ir_we, rf_we, reg_dst_rt, alu_src_imm, alu_op,
                mem_re, mem_we, mem_to_reg};
    endfunction

    // Expected strobe word for one cycle of an instruction of kind k in state s.
    function automatic logic [14:0] expect_vec(input int s, input kind_e k, input logic [2:0] a,
                                               input logic z, input logic fetch);
        logic pw, pb, iw, rw, rd, im, mr, mw, m2;
        logic [2:0] ao;
        {pw, pb, iw, rw, rd, im, mr, mw, m2} = '0;
        ao = 3'd0;
        if (s >= 2 && s <= 4 && k != K_BAD) begin
            ao = a;
            im = (k == K_I || k == K_LW || k == K_SW);
            rd = (k == K_I || k == K_LW);
        end
        if (s == 0) begin pw = fetch; iw = fetch; end
        if (s == 2 && k == K_BEQ) begin pw = z; pb = z; end
        if (s == 3) begin mr = (k == K_LW); mw = (k == K_SW); end
        if (s == 4) begin rw = 1'b1; m2 = (k == K_LW); end
        return {3'(s), pw, pb, iw, rw, rd, im, ao, mr, mw, m2};
    endfunction

    // Runs one instruction with s_if idle IF cycles and s_mem MEM wait cycles.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int s_if, input int s_mem, input string tag);
        kind_e k;
        logic [2:0] a;
        int sts[$];
        int m;
        logic fetch;
        m = 0;
        k = classify(o, f, a);
        for (int i = 0; i <= s_if; i++) sts.push_back(0);
        sts.push_back(1);
        sts.push_back(2);
        if (k == K_LW || k == K_SW) for (int i = 0; i <= s_mem; i++) sts.push_back(3);
        if (k == K_R || k == K_I || k == K_LW) sts.push_back(4);
        op = o; funct = f; zero = z;
        for (int c = 0; c < sts.size(); c++) begin
            fetch = 1'b0;
            case (sts[c])
                0: begin
                    if (c == s_if) begin
                        run = 1'b1; mem_rdy = 1'b1; fetch = 1'b1;
                    end else if ($urandom_range(0, 1) == 1) begin
                        run = 1'b0; mem_rdy = 1'($urandom_range(0, 1));
                    end else begin
                        run = 1'b1; mem_rdy = 1'b0;
                    end
                end
                3: begin
                    mem_rdy = (m == s_mem);
                    m++;
                    run = 1'($urandom_range(0, 1));
                end
                default: begin
                    run     = 1'($urandom_range(0, 1));
                    mem_rdy = 1'($urandom_range(0, 1));
                end
            endcase
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, c), 32'(obs()), 32'(expect_vec(sts[c], k, a, z, fetch)));
            @(posedge clk); #1;
        end
        exp_ret = (exp_ret + 1) % (1 << CW);
        check($sformatf("%s retired", tag), 32'(retired), 32'(exp_ret));
    endtask

    task automatic add_vec(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input logic [2:0] al, input logic im, input logic rd,
                           input int cy, input int rw);
        vec_t v;
        v.op = o; v.funct = f; v.z = z; v.alu = al; v.imm = im; v.rdst = rd;
        v.cyc = cy; v.rfw = rw;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; mem_rdy = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

        // Reset state, with fetch conditions already true
        @(negedge clk);
        check("rst state", 32'(state), 32'd0);
        check("rst ir_we", 32'(ir_we), 32'd0);
        check("rst pc_we", 32'(pc_we), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        check("rst retired", 32'(retired), 32'd0);
`ifdef RICS_ILLEGAL_TRAP_EN
        check("rst illegal", 32'(illegal), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;

        // run low holds the FSM in IF
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d state", i), 32'(state), 32'd0);
            check($sformatf("idle%0d ir_we", i), 32'(ir_we), 32'd0);
            @(posedge clk); #1;
        end
        check("idle retired", 32'(retired), 32'd0);

        add_vec(6'b000000, 6'b100000, 1'b0, 3'd2, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b100010, 1'b0, 3'd6, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b100100, 1'b0, 3'd0, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b100101, 1'b0, 3'd1, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b100110, 1'b0, 3'd3, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b100111, 1'b0, 3'd4, 1'b0, 1'b0, 4, 1);
        add_vec(6'b000000, 6'b101010, 1'b0, 3'd7, 1'b0, 1'b0, 4, 1);
        add_vec(6'b001000, 6'b000000, 1'b0, 3'd2, 1'b1, 1'b1, 4, 1);
        add_vec(6'b001110, 6'b000000, 1'b0, 3'd3, 1'b1, 1'b1, 4, 1);
        add_vec(6'b001100, 6'b000000, 1'b0, 3'd0, 1'b1, 1'b1, 4, 1);
        add_vec(6'b001101, 6'b000000, 1'b0, 3'd1, 1'b1, 1'b1, 4, 1);
        add_vec(6'b100011, 6'b000000, 1'b0, 3'd2, 1'b1, 1'b1, 5, 1);
        add_vec(6'b101011, 6'b000000, 1'b0, 3'd2, 1'b1, 1'b0, 4, 0);
        add_vec(6'b000100, 6'b000000, 1'b1, 3'd6, 1'b0, 1'b0, 3, 0);
        add_vec(6'b000100, 6'b000000, 1'b0, 3'd6, 1'b0, 1'b0, 3, 0);
`ifndef RICS_ILLEGAL_TRAP_EN
        add_vec(6'b000000, 6'b000001, 1'b0, 3'd0, 1'b0, 1'b0, 3, 0);
`endif

        foreach (tbl[i]) begin
            int cyc, rfw;
            logic [2:0] alu_ex;
            logic imm_ex, rd_wb;
            cyc = 0; rfw = 0; alu_ex = 3'd0; imm_ex = 1'b0; rd_wb = 1'b0;
            op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].z;
            run = 1'b1; mem_rdy = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (state == 3'd2) begin alu_ex = alu_op; imm_ex = alu_src_imm; end
                if (rf_we) begin rfw++; rd_wb = reg_dst_rt; end
                @(posedge clk); #1;
                cyc = c;
                if (state == 3'd0) break;
            end
            exp_ret = (exp_ret + 1) % (1 << CW);
            check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("vec%0d alu_op", i), 32'(alu_ex), 32'(tbl[i].alu));
            check($sformatf("vec%0d alu_src_imm", i), 32'(imm_ex), 32'(tbl[i].imm));
            check($sformatf("vec%0d reg_dst_rt", i), 32'(rd_wb), 32'(tbl[i].rdst));
            check($sformatf("vec%0d rf_we cnt", i), 32'(rfw), 32'(tbl[i].rfw));
            check($sformatf("vec%0d retired", i), 32'(retired), 32'(exp_ret));
        end

        do_instr(6'b100011, 6'd0, 1'b0, 0, 3, "lw_stall3");
        do_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
        do_instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_not");
        do_instr(6'b101011, 6'd0, 1'b0, 2, 2, "sw_stall");

        for (int n = 0; n < 80; n++) begin
            logic [5:0] o, f;
            int sel;
            logic [5:0] rf[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010};
            logic [5:0] io[7] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110,
                                  6'b100011, 6'b101011, 6'b000100};
`ifdef RICS_ILLEGAL_TRAP_EN
            sel = $urandom_range(0, 1);
`else
            sel = $urandom_range(0, 3);
`endif
            f = 6'($urandom_range(0, 63));
            case (sel)
                0: begin o = 6'b000000; f = rf[$urandom_range(0, 6)]; end
                1: o = io[$urandom_range(0, 6)];
                2: o = 6'b111111;
                default: begin o = 6'b000000; f = 6'b000011; end
            endcase
            do_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        // Unknown opcode
`ifdef RICS_ILLEGAL_TRAP_EN
        op = 6'b111111; funct = 6'd0; run = 1'b1; mem_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("halt%0d state", i), 32'(state), 32'd5);
            check($sformatf("halt%0d illegal", i), 32'(illegal), 32'd1);
            check($sformatf("halt%0d strobes", i), 32'(obs()), 32'({3'd5, 12'd0}));
            check($sformatf("halt%0d retired", i), 32'(retired), 32'(exp_ret));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("halt rst illegal", 32'(illegal), 32'd0);
        check("halt rst state", 32'(state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0;
`else
        do_instr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal_nop");
`endif

        // Reset in the middle of a stalled store
        op = 6'b101011; funct = 6'd0; run = 1'b1; mem_rdy = 1'b1;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("sw mem state", 32'(state), 32'd3);
        check("sw mem_we", 32'(mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("sw rst mem_we", 32'(mem_we), 32'd0);
        check("sw rst state", 32'(state), 32'd0);
        check("sw rst retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
